// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing defaults, colour type, palette and test-bar helper
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam logic [9:0] COORD_INVALID = 10'h3FF;

  typedef logic [23:0] rgb_t;

  localparam rgb_t RGB_BLACK        = 24'h000000;
  localparam rgb_t RGB_WHITE        = 24'hFFFFFF;
  localparam rgb_t RGB_LIGHT_GREEN  = 24'h58D858;
  localparam rgb_t RGB_DARK_GREEN   = 24'h00A800;
  localparam rgb_t RGB_LIGHT_ORANGE = 24'hFCA048;
  localparam rgb_t RGB_DARK_ORANGE  = 24'hC84C0C;

  // Eight 80-pixel colour bars across the visible line, left to right.
  function automatic rgb_t test_bar(input logic [9:0] x);
    logic [2:0] bar;
    rgb_t       colour;
    bar = 3'(x / 10'd80);
    case (bar)
      3'd0:    colour = 24'hFFFFFF;
      3'd1:    colour = 24'hFFFF00;
      3'd2:    colour = 24'h00FFFF;
      3'd3:    colour = 24'h00FF00;
      3'd4:    colour = 24'hFF00FF;
      3'd5:    colour = 24'hFF0000;
      3'd6:    colour = 24'h0000FF;
      default: colour = 24'h000000;
    endcase
    return colour;
  endfunction

endpackage

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - raster counters, published coordinates, raw syncs/de and frame_end
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
)
(
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       hs_raw,
  output logic       vs_raw,
  output logic       de_raw,
  output logic       frame_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] Y_TOP    = 12'(V_ACTIVE - 1);

  logic [11:0] h_cnt;
  logic [11:0] v_cnt;
  logic        idle;
  logic        in_active;
  logic [9:0]  y_flip;

  // idle holds the counters at 0,0 for one clock after reset so that cycle
  // still presents blanking coordinates; counting starts on the next clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      idle      <= 1'b1;
      frame_end <= 1'b0;
    end else begin
      idle      <= 1'b0;
      frame_end <= !idle && (h_cnt == '0) && (v_cnt == V_ACT);
      if (!idle) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
        end else begin
          h_cnt <= h_cnt + 12'd1;
        end
      end
    end
  end

  always_comb begin
    in_active = !rst && !idle && (h_cnt < H_ACT) && (v_cnt < V_ACT);
    y_flip    = 10'(Y_TOP - v_cnt);
  end

  assign de_raw  = in_active;
  assign pixel_x = in_active ? h_cnt[9:0] : COORD_INVALID;
  assign pixel_y = in_active ? y_flip : COORD_INVALID;
  assign hs_raw  = idle || !((h_cnt >= HS_START) && (h_cnt < HS_END));
  assign vs_raw  = idle || !((v_cnt >= VS_START) && (v_cnt < VS_END));

endmodule

// File: rtl/vga_frame_compositor.sv
// rtl/vga_frame_compositor.sv - raster timing, layer priority merge and VGA pin registers (option: TEST_PATTERN_EN)
module vga_frame_compositor
  import vga_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int H_FP        = H_FP_DEF,
  parameter int H_SYNC      = H_SYNC_DEF,
  parameter int H_BP        = H_BP_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int V_FP        = V_FP_DEF,
  parameter int V_SYNC      = V_SYNC_DEF,
  parameter int V_BP        = V_BP_DEF,
  parameter int NUM_LAYERS  = 4,
  parameter int PIX_LATENCY = 1
)
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [24*NUM_LAYERS-1:0]  layer_pixel,
  input  logic [NUM_LAYERS-1:0]     layer_valid,
  input  logic [23:0]               bg_pixel,
`ifdef TEST_PATTERN_EN
  input  logic                      test_mode,
`endif
  output logic [9:0]                current_pixel_x,
  output logic [9:0]                current_pixel_y,
  output logic                      vga_hs,
  output logic                      vga_vs,
  output logic [7:0]                vga_r,
  output logic [7:0]                vga_g,
  output logic [7:0]                vga_b,
  output logic                      vga_blank,
  output logic                      frame_end
);

  logic hs_raw;
  logic vs_raw;
  logic de_raw;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk       (clk),
    .rst       (rst),
    .pixel_x   (current_pixel_x),
    .pixel_y   (current_pixel_y),
    .hs_raw    (hs_raw),
    .vs_raw    (vs_raw),
    .de_raw    (de_raw),
    .frame_end (frame_end)
  );

  // Sync/de delay matching the renderers' coordinate-to-pixel latency.
  logic [PIX_LATENCY-1:0] hs_pipe;
  logic [PIX_LATENCY-1:0] vs_pipe;
  logic [PIX_LATENCY-1:0] de_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_pipe <= '1;
      vs_pipe <= '1;
      de_pipe <= '0;
    end else begin
      hs_pipe[0] <= hs_raw;
      vs_pipe[0] <= vs_raw;
      de_pipe[0] <= de_raw;
      for (int i = 1; i < PIX_LATENCY; i++) begin
        hs_pipe[i] <= hs_pipe[i-1];
        vs_pipe[i] <= vs_pipe[i-1];
        de_pipe[i] <= de_pipe[i-1];
      end
    end
  end

`ifdef TEST_PATTERN_EN
  logic [9:0] x_pipe [PIX_LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIX_LATENCY; i++) x_pipe[i] <= COORD_INVALID;
    end else begin
      x_pipe[0] <= current_pixel_x;
      for (int i = 1; i < PIX_LATENCY; i++) x_pipe[i] <= x_pipe[i-1];
    end
  end
`endif

  rgb_t merged;

  // Walk from the bottom layer up so the lowest asserted index ends up on top.
  always_comb begin
    merged = bg_pixel;
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      if (layer_valid[k]) merged = layer_pixel[24*k +: 24];
    end
`ifdef TEST_PATTERN_EN
    if (test_mode) merged = test_bar(x_pipe[PIX_LATENCY-1]);
`endif
    if (!de_pipe[PIX_LATENCY-1]) merged = RGB_BLACK;
  end

  rgb_t rgb_q;
  logic hs_q;
  logic vs_q;
  logic blank_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q   <= RGB_BLACK;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b1;
    end else begin
      rgb_q   <= merged;
      hs_q    <= hs_pipe[PIX_LATENCY-1];
      vs_q    <= vs_pipe[PIX_LATENCY-1];
      blank_q <= !de_pipe[PIX_LATENCY-1];
    end
  end

  assign vga_r     = rgb_q[23:16];
  assign vga_g     = rgb_q[15:8];
  assign vga_b     = rgb_q[7:0];
  assign vga_hs    = hs_q;
  assign vga_vs    = vs_q;
  assign vga_blank = blank_q;

endmodule

// File: doc/vga_frame_compositor.md
Name: vga_frame_compositor

Overview:
- Drives the VGA frame: generates the raster timing and publishes current_pixel_x/current_pixel_y to every sprite/overlay renderer.
- Collects each renderer's registered pixel and pixel_valid one cycle later, priority-merges them over a background colour, and drives the VGA pins with aligned syncs.
- Sits between all layer renderers and the board VGA connector.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- NUM_LAYERS, 4, number of layer inputs (1..8)
- PIX_LATENCY, 1, clocks from coordinate out to layer pixel in (1..3)

Ports:
- clk  in  1  pixel clock; the only clock
- rst  in  1  synchronous, active-high reset
- layer_pixel  in  24*NUM_LAYERS  layer k RGB888 at bits [24k+23:24k]
- layer_valid  in  NUM_LAYERS  layer k pixel is opaque
- bg_pixel  in  24  background colour, always opaque
- current_pixel_x  out  10  visible column, 0..H_ACTIVE-1; 10'h3FF in blanking
- current_pixel_y  out  10  visible row, bottom origin (0 = bottom line); 10'h3FF in blanking
- vga_hs  out  1  horizontal sync, active low
- vga_vs  out  1  vertical sync, active low
- vga_r / vga_g / vga_b  out  8 each  output colour
- vga_blank  out  1  high when output is outside the active area
- frame_end  out  1  one-clock pulse at the start of the first blanking line

Behaviour:
- Reset: the one clock, one reset already decided — clk, synchronous active-high rst. Reset clears h_cnt, v_cnt and the delay pipes. While and one cycle after rst: vga_hs=1, vga_vs=1, RGB=0, vga_blank=1, frame_end=0, coordinates=10'h3FF. Reset mid-frame restarts at h_cnt=0, v_cnt=0; no partial sync pulse is extended.
- Counters (stage 0):
  - h_cnt counts 0..H_TOTAL-1, where H_TOTAL = sum of the H parameters (800). On wrap, h_cnt returns to 0 and v_cnt increments.
  - v_cnt counts 0..V_TOTAL-1 (525). On wrap at the last line's last clock, both counters return to 0.
- Coordinates (stage 0, combinational from counters):
  - x = h_cnt when h_cnt < H_ACTIVE, else 10'h3FF.
  - y = V_ACTIVE-1-v_cnt when v_cnt < V_ACTIVE, else 10'h3FF. Both read 10'h3FF if either is out of range.
- Sync (stage 0, raw):
  - hs_raw low for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vs_raw low for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC.
  - de_raw = both counters in the active range.
- Alignment: hs_raw, vs_raw and de_raw pass through a PIX_LATENCY-deep shift register, so they line up with the layer inputs for the same coordinate.
- Merge (combinational at stage PIX_LATENCY): the lowest-index asserted layer_valid wins (layer 0 = top). With no layer valid, bg_pixel is used. With de delayed low, colour is 24'h000000.
- Output register: RGB, vga_hs, vga_vs, vga_blank (= !de) all registered. Total latency from coordinate to pins is PIX_LATENCY+1 clocks; syncs and colour share the same latency.
- frame_end: registered pulse when h_cnt==0 && v_cnt==V_ACTIVE. Game logic updates sprite positions on it.
- Layer inputs are ignored whenever de is low, even if a layer asserts valid.

Optional Feature:
- TEST_PATTERN_EN: when defined, adds input test_mode (1 bit, sampled per clock). With test_mode=1, merged colour = 8 vertical bars 80 px wide, following the delayed x column: white, yellow, cyan, green, magenta, red, blue, black. Layers are ignored; timing is unchanged.
- When undefined, the port and logic are absent and behaviour is exactly as above.

Decomposition:
- Shared package vga_pkg: timing defaults, the COORD_INVALID constant (10'h3FF), a 24-bit rgb_t, and the colour constants used in-game (black, white, light_green, dark_green, light_orange, dark_orange).
- One sub-module, vga_timing: counters, coordinates, raw syncs/de, frame_end.
- The compositor instantiates vga_timing and adds the delay pipe, priority merge and output registers.

Test Plan:
- Release rst, count clocks: vga_hs low for 96 clocks every 800; vga_vs low for 2 lines every 525 lines; first hs falling edge at clock 656+PIX_LATENCY+1 after reset release.
- At h_cnt=0, v_cnt=0: current_pixel_x=0, current_pixel_y=479. At h_cnt=640: both coordinates 10'h3FF.
- Layer 1 valid with 24'hFCA048, layer 0 invalid, bg 24'h58D858: output 24'hFCA048. Assert layer 0 valid with 24'hFFFFFF: output 24'hFFFFFF.
- Model layers as 1-cycle registered echoes of the coordinates; drive a layer valid only for x in 100..149, y in 200..209: exactly 500 pixels per frame show the layer colour, at correct columns, aligned to vga_blank.
- Hold all layer_valid=1 through blanking: RGB stays 0 and vga_blank=1 in blanking. frame_end pulses once per 420000 clocks, at v_cnt=480.
- Assert rst at mid-line (h_cnt=300, v_cnt=100) for 1 clock: next cycle outputs are in reset state. The frame restarts at 0,0 and no sync pulse is shorter or longer than nominal afterward.
